// File: rtl/prewitt_window_gen.sv
// Raster-order pixel stream to registered 3x3 neighbourhood for a Prewitt operator.
// Two line buffers plus a 3x3 shift window; win_valid marks fully in-frame windows.
module prewitt_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic              win_valid,
    output logic [XW-1:0]     win_x,
    output logic [YW-1:0]     win_y,
    output logic              frame_done
);

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic [XW-1:0]     col_q, col_d, c;
    logic [YW-1:0]     row_q, row_d, r;
    logic              win_valid_q, win_valid_d;
    logic [XW-1:0]     win_x_q, win_x_d;
    logic [YW-1:0]     win_y_q, win_y_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] top, mid;

    // sof forces the current pixel to (0,0) regardless of the counters.
    always_comb begin
        c   = sof ? '0 : col_q;
        r   = sof ? '0 : row_q;
        top = lb1[c];
        mid = lb0[c];

        win_d        = win_q;
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        frame_done_d = 1'b0;

        if (pix_valid) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = top;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = mid;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_in;

            win_valid_d = (r >= YW'(2)) && (c >= XW'(2));
            win_x_d     = c - XW'(1);
            win_y_d     = r - YW'(1);

            if (c < XW'(IMG_W - 1)) begin
                col_d = c + XW'(1);
                row_d = r;
            end else begin
                col_d        = '0;
                row_d        = (r == YW'(IMG_H - 1)) ? '0 : r + YW'(1);
                frame_done_d = (r == YW'(IMG_H - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: line buffers are deliberately not reset so they map to plain RAM;
    // rows 0 and 1 of every frame overwrite them before any window uses them.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[c] <= mid;
            lb0[c] <= pix_in;
        end
    end

    assign p0         = win_q[0];
    assign p1         = win_q[1];
    assign p2         = win_q[2];
    assign p3         = win_q[3];
    assign p4         = win_q[4];
    assign p5         = win_q[5];
    assign p6         = win_q[6];
    assign p7         = win_q[7];
    assign p8         = win_q[8];
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule
